// File: rtl/cartesian_to_polar_if.sv
// cartesian_to_polar_if: start/done handshake plus operand and result bus for cartesian_to_polar
// master drives start/x_value/y_value and observes busy/done/r_theta/out_of_range; slave is the converter side.
interface cartesian_to_polar_if;
  logic start;
  logic [8:0] x_value;
  logic [8:0] y_value;
  logic busy;
  logic done;
  logic [11:0] r_theta;
  logic out_of_range;
  modport master (output start, x_value, y_value, input busy, done, r_theta, out_of_range);
  modport slave (input start, x_value, y_value, output busy, done, r_theta, out_of_range);
endinterface

// File: rtl/cartesian_to_polar.sv
// cartesian_to_polar: signed (x, y) to packed {sector[11:8], r[7:0]} with fixed 10-cycle start-to-done latency
// Ports: clock; reset_n (synchronous, active-low); bus (slave): start, x_value, y_value in;
// busy, done (1-cycle pulse), r_theta, out_of_range (y < 0) out, results held until the next done.
module cartesian_to_polar (
  input logic clock,
  input logic reset_n,
  cartesian_to_polar_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, SQUARE = 2'd1, ROOT = 2'd2, FINISH = 2'd3;
  logic [1:0] state;
  logic [8:0] x_q, y_q, ax, ay;
  logic [16:0] ay128, ax74, ax222;
  logic [17:0] sum;
  logic [1:0] k;
  logic [2:0] sector, sector_q, cnt_q;
  logic [15:0] rad_q;
  logic [9:0] rem_q;
  logic [7:0] root_q;
  logic [11:0] rem_sh, trial;
  logic fits, sat_q, oor_q;
  always_comb begin
    ax = x_q[8] ? ~x_q + 9'd1 : x_q;
    ay = y_q[8] ? ~y_q + 9'd1 : y_q;
    sum = 18'(ax) * 18'(ax) + 18'(ay) * 18'(ay);
    ay128 = {1'b0, ay, 7'd0};
    ax74 = 17'(ax) * 17'd74;
    ax222 = 17'(ax) * 17'd222;
    k = ay128 < ax74 ? 2'd0 : ay128 < ax222 ? 2'd1 : 2'd2;
    // Behind the radar clamps to the edge sector on the same side; the 90 degree axis belongs to sector 2.
    sector = y_q[8] ? (x_q[8] ? 3'd5 : 3'd0)
           : x_q == 9'd0 ? (y_q == 9'd0 ? 3'd0 : 3'd2)
           : x_q[8] ? 3'd5 - {1'b0, k} : {1'b0, k};
    // Restoring square root step: bring down two radicand bits, try subtracting 4*root+1.
    rem_sh = {rem_q, rad_q[15:14]};
    trial = {2'b00, root_q, 2'b01};
    fits = rem_sh >= trial;
  end
  assign bus.busy = state != IDLE || bus.done;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      bus.done <= 1'b0;
      bus.r_theta <= 12'h000;
      bus.out_of_range <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          x_q <= bus.x_value;
          y_q <= bus.y_value;
          state <= SQUARE;
        end
        SQUARE: begin
          rad_q <= sum[15:0];
          sat_q <= |sum[17:16];
          sector_q <= sector;
          oor_q <= y_q[8];
          rem_q <= 10'd0;
          root_q <= 8'd0;
          cnt_q <= 3'd0;
          state <= ROOT;
        end
        ROOT: begin
          rad_q <= {rad_q[13:0], 2'b00};
          rem_q <= 10'(fits ? rem_sh - trial : rem_sh);
          root_q <= {root_q[6:0], fits};
          cnt_q <= cnt_q + 3'd1;
          state <= cnt_q == 3'd7 ? FINISH : ROOT;
        end
        default: begin
          bus.r_theta <= {1'b0, sector_q, sat_q ? 8'hff : root_q};
          bus.out_of_range <= oor_q;
          bus.done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cartesian_to_polar.sv
// tb_cartesian_to_polar: randomized and directed checks of cartesian_to_polar against an arithmetic reference
module tb_cartesian_to_polar;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  cartesian_to_polar_if bus ();
  cartesian_to_polar dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  function automatic logic [12:0] model(input int x, input int y);
    int ax, ay, s, r, k, idx;
    ax = x < 0 ? -x : x;
    ay = y < 0 ? -y : y;
    s = ax * ax + ay * ay;
    r = 0;
    while (r < 255 && (r + 1) * (r + 1) <= s) r++;
    k = (128 * ay < 74 * ax) ? 0 : (128 * ay < 222 * ax) ? 1 : 2;
    if (y < 0) idx = x < 0 ? 5 : 0;
    else if (x > 0) idx = k;
    else if (x < 0) idx = 5 - k;
    else idx = y != 0 ? 2 : 0;
    return {y < 0, 4'(idx), 8'(r)};
  endfunction
  task automatic run_conv(input int x, input int y, output int lat);
    bus.x_value = 9'(x);
    bus.y_value = 9'(y);
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int e = 1; e <= 20 && lat < 0; e++) begin
      @(posedge clock); #1;
      if (bus.done) lat = e;
    end
  endtask
  task automatic test_reset();
    int lat;
    bus.start = 1'b1;
    bus.x_value = 9'd100;
    bus.y_value = 9'd0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vecs++; if (bus.r_theta !== 12'h000) begin errs++; $display("FAIL reset_r_theta: got %h expected 000", bus.r_theta); end
    vecs++; if (bus.out_of_range !== 1'b0) begin errs++; $display("FAIL reset_oor: got %b expected 0", bus.out_of_range); end
    reset_n = 1'b1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    run_conv(100, 0, lat);
    vecs++; if (lat !== 10) begin errs++; $display("FAIL reset_first_latency: got %0d expected 10", lat); end
    vecs++; if (bus.r_theta !== 12'h064) begin errs++; $display("FAIL reset_first_result: got %h expected 064", bus.r_theta); end
    @(posedge clock); #1;
    vecs++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL done_single_cycle: got done=%b busy=%b expected 0 0", bus.done, bus.busy); end
  endtask
  task automatic test_sweep();
    int tx[10] = '{100, 0, -60, 70, -100, 255, -256, 0, 30, -30};
    int ty[10] = '{0, 100, 80, 70, 5, 255, 0, 0, -40, -40};
    logic [12:0] te[10] = '{13'h0064, 13'h0264, 13'h0464, 13'h0162, 13'h0564,
                            13'h01ff, 13'h05ff, 13'h0000, 13'h1032, 13'h1532};
    int lat;
    logic [12:0] got;
    for (int i = 0; i < 10; i++) begin
      run_conv(tx[i], ty[i], lat);
      got = {bus.out_of_range, bus.r_theta};
      vecs++; if (lat !== 10) begin errs++; $display("FAIL sweep_latency (%0d,%0d): got %0d expected 10", tx[i], ty[i], lat); end
      vecs++; if (got !== te[i]) begin errs++; $display("FAIL sweep (%0d,%0d): got oor/r_theta %h expected %h", tx[i], ty[i], got, te[i]); end
    end
  endtask
  task automatic test_random();
    int x, y, lat;
    logic [12:0] exp_v, got;
    for (int i = 0; i < 60; i++) begin
      x = int'($urandom_range(0, 511)) - 256;
      y = int'($urandom_range(0, 511)) - 256;
      if (i % 4 == 0) y = int'($urandom_range(0, 255));
      if (i % 9 == 0) x = 0;
      exp_v = model(x, y);
      run_conv(x, y, lat);
      got = {bus.out_of_range, bus.r_theta};
      vecs++; if (lat !== 10) begin errs++; $display("FAIL random_latency (%0d,%0d): got %0d expected 10", x, y, lat); end
      vecs++; if (got !== exp_v) begin errs++; $display("FAIL random (%0d,%0d): got oor/r_theta %h expected %h", x, y, got, exp_v); end
    end
  endtask
  task automatic test_back_to_back();
    int first_e, second_e, ndone;
    logic stable, busy_held;
    logic [11:0] r1, r2;
    bus.x_value = 9'd100;
    bus.y_value = 9'd0;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    first_e = -1; second_e = -1; ndone = 0; stable = 1'b1; busy_held = 1'b0;
    r1 = 12'h000; r2 = 12'h000;
    for (int e = 1; e <= 21; e++) begin
      if (e == 4) begin bus.x_value = 9'd0; bus.y_value = 9'd100; end
      bus.start = (e == 4 || e >= 11);
      @(posedge clock); #1;
      if (bus.done) begin
        ndone++;
        if (first_e < 0) begin first_e = e; r1 = bus.r_theta; end
        else begin second_e = e; r2 = bus.r_theta; end
      end
      if (e == 11) busy_held = bus.busy;
      if (e > 10 && e < 21 && bus.r_theta !== r1) stable = 1'b0;
    end
    bus.start = 1'b0;
    vecs++; if (ndone !== 2) begin errs++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    vecs++; if (first_e !== 10) begin errs++; $display("FAIL b2b_first_edge: got %0d expected 10", first_e); end
    vecs++; if (r1 !== 12'h064) begin errs++; $display("FAIL b2b_first_result: got %h expected 064", r1); end
    vecs++; if (busy_held !== 1'b1) begin errs++; $display("FAIL b2b_restart_busy: got %b expected 1", busy_held); end
    vecs++; if (stable !== 1'b1) begin errs++; $display("FAIL b2b_hold_stable: got %b expected 1", stable); end
    vecs++; if (second_e !== 21) begin errs++; $display("FAIL b2b_second_edge: got %0d expected 21", second_e); end
    vecs++; if (r2 !== 12'h264) begin errs++; $display("FAIL b2b_second_result: got %h expected 264", r2); end
    @(posedge clock); #1;
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL b2b_idle_after: got busy=%b expected 0", bus.busy); end
  endtask
  task automatic test_reset_mid();
    int lat;
    logic saw_done, nonzero;
    bus.x_value = 9'd100;
    bus.y_value = 9'd0;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    saw_done = 1'b0; nonzero = 1'b0;
    for (int e = 6; e <= 16; e++) begin
      if (bus.done) saw_done = 1'b1;
      if (bus.r_theta !== 12'h000 || bus.out_of_range !== 1'b0 || bus.busy !== 1'b0) nonzero = 1'b1;
      @(posedge clock); #1;
    end
    vecs++; if (saw_done !== 1'b0) begin errs++; $display("FAIL midreset_no_done: got %b expected 0", saw_done); end
    vecs++; if (nonzero !== 1'b0) begin errs++; $display("FAIL midreset_outputs_zero: got %b expected 0", nonzero); end
    run_conv(-30, -40, lat);
    vecs++; if (lat !== 10) begin errs++; $display("FAIL midreset_restart_latency: got %0d expected 10", lat); end
    vecs++; if ({bus.out_of_range, bus.r_theta} !== 13'h1532) begin errs++; $display("FAIL midreset_restart_result: got %h expected 1532", {bus.out_of_range, bus.r_theta}); end
  endtask
  initial begin
    bus.start = 1'b1;
    bus.x_value = 9'd0;
    bus.y_value = 9'd0;
    test_reset();
    test_sweep();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/cartesian_to_polar.md
# cartesian_to_polar

Sequential converter from a signed cartesian point (x, y), in the rover/radar frame, to the packed 12-bit r_theta word used throughout the main FPGA: r in [7:0], a 4-bit sector index in [11:8]. It is the inverse of the polar-to-cartesian path feeding orientation math. Path planning uses it to turn a computed target offset back into a radar-style coordinate for comparison and display. Uses a start/done handshake with fixed latency. The sector grid is the radar's six 30° sectors, centred on 15° + 30°·n for n = 0..5.

## Interface
- No parameters. Sector count (6), fixed-point tan constants and latency are fixed by design.
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- x_value  in  9  signed two's-complement x, -256..255
- y_value  in  9  signed two's-complement y, -256..255
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle pulse; r_theta and out_of_range valid this cycle
- r_theta  out  12  [7:0] = r, [11:8] = sector index 0..5; held until the next done
- out_of_range  out  1  y < 0, so the point is behind the radar; held with r_theta

## Operation
- States: IDLE, SQUARE, ROOT, FINISH.
- **IDLE**
  - On start = 1, register x_value and y_value and go to SQUARE.
  - start is ignored in every other state; there is no queueing.
- **SQUARE** (1 cycle)
  - ax = |x| and ay = |y|. The 9-bit magnitude is used, so |-256| = 256.
  - sum = ax² + ay², 18-bit unsigned.
  - Compute the sector (see below), register it, and go to ROOT.
- **ROOT** (8 cycles)
  - Restoring bit-serial integer square root of sum[15:0], one result bit per cycle, MSB first.
  - If sum[17:16] ≠ 0, force r = 255 (saturate).
  - Result: r = min(255, floor(sqrt(x² + y²))).
- **FINISH** (1 cycle)
  - Load r_theta and out_of_range, pulse done, return to IDLE.
- **Sector rule.** Uses unsigned 17-bit compares; tan30 ≈ 74/128 and tan60 ≈ 222/128.
  - Let k = 0 if 128·ay < 74·ax; k = 1 else if 128·ay < 222·ax; k = 2 otherwise.
  - x > 0 → index k. x < 0 → index 5 − k.
  - x = 0 with y ≠ 0 → index 2 (the 90° tie goes to the lower index).
  - Origin (0, 0) → index 0, r = 0.
- **Out of range (y < 0)**
  - Set out_of_range = 1.
  - Sector clamps to index 0 if x ≥ 0, index 5 if x < 0.
  - r is still computed normally.
- Indices 6..15 are never produced.

## Timing
- **Reset** (reset_n = 0 at an edge):
  - Next state is IDLE; busy = 0, done = 0, r_theta = 0, out_of_range = 0.
  - Reset overrides an in-flight computation; no done is produced for it.
- **Latency.** Start is sampled at edge E0. busy is high after E0. done is high during the cycle after edge E10 (1 SQUARE + 8 ROOT + FINISH entry). busy drops together with done at E11.
- **Throughput.** The earliest next start is sampled at E11, giving one conversion per 11 cycles.
- start = 1 during busy cycles is ignored. A start held high through done is re-sampled at E11 and begins a new conversion.
- x_value and y_value may change freely after E0.
- Outputs change only at the FINISH edge or on reset.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles with start = 1 → busy = 0, done = 0, r_theta = 12'h000, out_of_range = 0. With reset released, start at E0 → done exactly at E10, single cycle.
- Quadrant/sector sweep:
  - (100, 0) → r = 100, idx 0.
  - (0, 100) → r = 100, idx 2.
  - (-60, 80) → r = 100, idx 4.
  - (70, 70) → r = 98, idx 1.
  - (-100, 5) → r = 100, idx 5.
  - out_of_range = 0 for all.
- Saturation and extremes:
  - (255, 255) → r = 255, idx 1.
  - (-256, 0) → r = 255, idx 5.
  - (0, 0) → r = 0, idx 0.
- Behind radar: (30, -40) → r = 50, idx 0, out_of_range = 1. (-30, -40) → r = 50, idx 5, out_of_range = 1.
- Handshake:
  - Start (100, 0) at E0.
  - Pulse start with (0, 100) at E4 → ignored; one done at E10 with r = 100, idx 0.
  - Hold start high with inputs changed to (0, 100) → second done at E21 with idx 2; r_theta stable between the two dones.
- Reset mid-operation: start (100, 0), drop reset_n at E5 → no done. Outputs read 0 from E6 onward. A new start after release completes in 10 cycles.
